// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the rotated-immediate operand encoder.
// Fixes the 16-step, 2-bit rotation grid and the {rot, imm8} field layout.
package imm_enc_pkg;

    localparam int DATA_W    = 32;
    localparam int ROT_STEPS = 16;
    localparam int ROT_SHIFT = 2;
    localparam int IMM8_W    = 8;
    localparam int ROT_W     = 4;
    localparam int SHIFTER_W = ROT_W + IMM8_W;

    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [ROT_W-1:0]  rot;
        logic [IMM8_W-1:0] imm8;
    } shifter_t;

    // Outcome of one search step: whether any rotation fitted, and how.
    typedef struct packed {
        logic     hit;
        logic     inverted;
        shifter_t field;
    } match_t;

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                               input int unsigned       amt);
        return (amt == 0) ? v : ((v << amt) | (v >> (DATA_W - amt)));
    endfunction

endpackage

// File: rtl/imm_rot_match.sv
// Tests one already-rotated candidate for an 8-bit direct or inverted fit.
// Direct wins when both tests pass (only possible for impossible widths, kept for clarity).
module imm_rot_match
    import imm_enc_pkg::*;
(
    input  logic [DATA_W-1:0] cand_i,
    output logic              direct_hit_o,
    output logic              inverse_hit_o,
    output logic [IMM8_W-1:0] imm8_o
);

    assign direct_hit_o  = ~|cand_i[DATA_W-1:IMM8_W];
    assign inverse_hit_o = &cand_i[DATA_W-1:IMM8_W];
    assign imm8_o        = direct_hit_o ? cand_i[IMM8_W-1:0] : ~cand_i[IMM8_W-1:0];

endmodule

// File: rtl/imm_operand_encoder.sv
// Encodes a 32-bit constant as {rot, imm8} (value = imm8 ROR 2*rot), or flags its inverse.
// IMM_ENCODER_PARALLEL_EN: test all 16 rotations in a single SEARCH cycle instead of iterating.
module imm_operand_encoder
    import imm_enc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SHIFTER_W-1:0] out_shifter,
    output logic                 out_encodable,
    output logic                 out_inverted
);

    enc_state_e        state_q;
    logic [DATA_W-1:0] work_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_encodable_q;
    logic              out_inverted_q;
    shifter_t          shifter_q;

    match_t            match;
    logic              search_last;

`ifdef IMM_ENCODER_PARALLEL_EN

    logic [ROT_STEPS-1:0] direct_hit;
    logic [ROT_STEPS-1:0] inverse_hit;
    logic [IMM8_W-1:0]    imm8_r [ROT_STEPS];

    for (genvar r = 0; r < ROT_STEPS; r++) begin : g_rot
        logic [DATA_W-1:0] cand;
        assign cand = rotl(work_q, ROT_SHIFT * r);

        imm_rot_match u_match (
            .cand_i        (cand),
            .direct_hit_o  (direct_hit[r]),
            .inverse_hit_o (inverse_hit[r]),
            .imm8_o        (imm8_r[r])
        );
    end

    // Scan from the highest rotation down so the lowest hit is written last and wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        match = '0;
        for (int r = ROT_STEPS - 1; r >= 0; r--) begin
            if (direct_hit[r] || inverse_hit[r]) begin
                match.hit        = 1'b1;
                match.inverted   = !direct_hit[r];
                match.field.rot  = ROT_W'(r);
                match.field.imm8 = imm8_r[r];
            end
        end
    end

    assign search_last = 1'b1;

`else

    logic [ROT_W-1:0]  cnt_q;
    logic              direct_hit;
    logic              inverse_hit;
    logic [IMM8_W-1:0] imm8;

    imm_rot_match u_match (
        .cand_i        (work_q),
        .direct_hit_o  (direct_hit),
        .inverse_hit_o (inverse_hit),
        .imm8_o        (imm8)
    );

    always_comb begin
        match            = '0;
        match.hit        = direct_hit || inverse_hit;
        match.inverted   = !direct_hit;
        match.field.rot  = cnt_q;
        match.field.imm8 = imm8;
    end

    assign search_last = (cnt_q == ROT_LAST);

`endif

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            work_q          <= '0;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            out_encodable_q <= 1'b0;
            out_inverted_q  <= 1'b0;
            shifter_q       <= '0;
`ifndef IMM_ENCODER_PARALLEL_EN
            cnt_q           <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= ST_SEARCH;
                        work_q     <= in_value;
                        in_ready_q <= 1'b0;
`ifndef IMM_ENCODER_PARALLEL_EN
                        cnt_q      <= '0;
`endif
                    end
                end

                ST_SEARCH: begin
                    if (match.hit) begin
                        state_q         <= ST_DONE;
                        out_valid_q     <= 1'b1;
                        out_encodable_q <= 1'b1;
                        out_inverted_q  <= match.inverted;
                        shifter_q       <= match.field;
                    end else if (search_last) begin
                        state_q         <= ST_DONE;
                        out_valid_q     <= 1'b1;
                        out_encodable_q <= 1'b0;
                        out_inverted_q  <= 1'b0;
                        shifter_q       <= '0;
                    end else begin
`ifndef IMM_ENCODER_PARALLEL_EN
                        work_q <= rotl(work_q, ROT_SHIFT);
                        cnt_q  <= cnt_q + 1'b1;
`endif
                    end
                end

                ST_DONE: begin
                    // Result registers hold their values until the consumer takes them.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_shifter   = shifter_q;
    assign out_encodable = out_encodable_q;
    assign out_inverted  = out_inverted_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Directed and randomised bench for imm_operand_encoder with a queue scoreboard.
// Honours IMM_ENCODER_PARALLEL_EN for the expected result latency.
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_shifter;
    logic        out_encodable;
    logic        out_inverted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] value;
        logic [11:0] shifter;
        logic        enc;
        logic        inv;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    imm_operand_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_shifter   (out_shifter),
        .out_encodable (out_encodable),
        .out_inverted  (out_inverted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (n == 0) ? v : ((v << n) | (v >> (32 - n)));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
    endfunction

    // Reference search: lowest rotation first, direct before inverse.
    function automatic exp_t model(input logic [31:0] v);
        exp_t        e;
        logic [31:0] w;
        e.value   = v;
        e.shifter = '0;
        e.enc     = 1'b0;
        e.inv     = 1'b0;
        e.lat     = 16;
        for (int c = 0; c < 16; c++) begin
            w = rol(v, 2 * c);
            if (!e.enc && w[31:8] == 24'h000000) begin
                e.enc = 1'b1; e.shifter = {4'(c), w[7:0]}; e.lat = c + 1;
            end else if (!e.enc && w[31:8] == 24'hFFFFFF) begin
                e.enc = 1'b1; e.inv = 1'b1; e.shifter = {4'(c), ~w[7:0]}; e.lat = c + 1;
            end
        end
`ifdef IMM_ENCODER_PARALLEL_EN
        e.lat = 1;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [31:0] v);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        sb_q.push_back(model(v));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("valid_timeout", 32'(lat < 40), 32'd1);
    endtask

    task automatic compare_front(input int lat);
        exp_t        e;
        logic [31:0] dec;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("shifter", 32'(out_shifter), 32'(e.shifter));
        check("encodable", 32'(out_encodable), 32'(e.enc));
        check("inverted", 32'(out_inverted), 32'(e.inv));
        check("latency", 32'(lat), 32'(e.lat));
        if (out_encodable) begin
            dec = ror(32'(out_shifter[7:0]), 2 * int'(out_shifter[11:8]));
            check("decode", out_inverted ? ~dec : dec, e.value);
        end
    endtask

    task automatic run_req(input logic [31:0] v, input logic [11:0] exp_sh,
                           input logic exp_enc, input logic exp_inv, input int exp_lat_iter);
        int lat;
        int exp_lat = exp_lat_iter;
`ifdef IMM_ENCODER_PARALLEL_EN
        exp_lat = 1;
`endif
        out_ready = 1'b1;
        issue(v);
        wait_valid(lat);
        compare_front(lat);
        check("dir_shifter", 32'(out_shifter), 32'(exp_sh));
        check("dir_encodable", 32'(out_encodable), 32'(exp_enc));
        check("dir_inverted", 32'(out_inverted), 32'(exp_inv));
        check("dir_latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check("post_accept_valid", 32'(out_valid), 32'd0);
        check("post_accept_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          vlat;
        bit          done;
        logic [31:0] v;
        logic [7:0]  b;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_shifter", 32'(out_shifter), 32'd0);
        check("rst_encodable", 32'(out_encodable), 32'd0);
        check("rst_inverted", 32'(out_inverted), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_req(32'h000000FF, 12'h0FF, 1'b1, 1'b0, 1);
        run_req(32'hFF000000, 12'h4FF, 1'b1, 1'b0, 5);
        run_req(32'hF000000F, 12'h2FF, 1'b1, 1'b0, 3);
        run_req(32'hFFFFFF00, 12'h0FF, 1'b1, 1'b1, 1);
        run_req(32'h00000102, 12'h000, 1'b0, 1'b0, 16);
        run_req(32'h00000000, 12'h000, 1'b1, 1'b0, 1);
        run_req(32'hFFFFFFFF, 12'h000, 1'b1, 1'b1, 1);
        run_req(32'h00000104, 12'hF41, 1'b1, 1'b0, 16);

        // Back-pressure: result must hold and further requests must be ignored.
        out_ready = 1'b0;
        issue(32'hFF000000);
        wait_valid(lat);
        compare_front(lat);
        repeat (5) begin
            in_valid = 1'b1;
            in_value = 32'h12345678;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_shifter", 32'(out_shifter), 32'h4FF);
            check("hold_encodable", 32'(out_encodable), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("ignored_req_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a search discards it.
        issue(32'h00000102);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_shifter", 32'(out_shifter), 32'd0);
        check("midrst_encodable", 32'(out_encodable), 32'd0);
        check("midrst_inverted", 32'(out_inverted), 32'd0);
        sb_q.delete();
        repeat (17) @(negedge clk);
        check("midrst_no_result", 32'(out_valid), 32'd0);
        run_req(32'h000000FF, 12'h0FF, 1'b1, 1'b0, 1);

        // Random values with random consumer back-pressure.
        repeat (1200) begin
            b = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = rol({24'h0, b}, 2 * int'($urandom_range(0, 15)));
                2:       v = ~rol({24'h0, b}, 2 * int'($urandom_range(0, 15)));
                default: v = rol({24'h0, b, 1'b1} >> 1, int'($urandom_range(0, 31)));
            endcase
            out_ready = 1'b0;
            issue(v);
            cyc  = 0;
            vlat = -1;
            done = 1'b0;
            while (!done && cyc < 80) begin
                @(negedge clk);
                cyc++;
                if (out_valid && vlat < 0) vlat = cyc;
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    compare_front(vlat);
                    @(negedge clk);
                    done = 1'b1;
                end
            end
            check("rand_timeout", 32'(done), 32'd1);
        end
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
